mc_sdram_adr_decode: RTL and testbench
======================================

// Module: mc_sdram_adr_decode
// PURPOSE
// Memory-side counterpart of the controller's SDRAM address mux. It samples the
// SDRAM command and address pins every clock and tracks the open row of each of
// the 4 banks and the current mode register. It rebuilds the byte address of
// every read/write burst beat and flags protocol errors. It serves the SDRAM
// responder model and the bus monitor in the controller testbench.
// PARAMETERS
// CL_MAX   3   deepest CAS latency supported; read beats are delayed by up to CL_MAX cycles
// PORTS
// clk       in   1   system clock
// rst       in   1   synchronous, active-high reset
// csc       in   32  chip-select config: [5:4] bus_width, [7:6] mem_size, [9] bas
// cs_       in   1   SDRAM chip select, active low
// ras_      in   1   row address strobe, active low
// cas_      in   1   column address strobe, active low
// we_       in   1   write enable, active low
// mc_addr   in   24  SDRAM address: [14:13] bank, [12:0] A12..A0
// resp_valid out 1   one beat address valid this cycle
// resp_we   out  1   beat is a write
// resp_adr  out  32  reconstructed byte address of beat
// resp_last out  1   final beat of burst
// resp_err  out  1   one-cycle protocol-error pulse
// bank_open out  4   per-bank row-open flags
// mode_bl   out  3   mode register A2:A0
// mode_cl   out  2   CAS latency, 2 or 3
// BEHAVIOUR
// - Reset: all outputs 0, except mode_cl=2. Row registers are cleared, the burst is
//   idle, and the read delay line is flushed. Reset mid-burst aborts the burst with no further beats.
// - Command {ras_,cas_,we_} when cs_=0: 111 NOP, 011 ACT, 101 RD, 100 WR, 110 BT,
//   010 PRE, 001 REF, 000 LMR. cs_=1 is treated as NOP.
// - ACT: row[bank] <= A12:0, bank_open[bank] <= 1 (next cycle).
//   ACT to an already-open bank: resp_err, state unchanged.
// - PRE: A10=1 closes all banks, A10=0 closes bank[14:13]. A burst in progress
//   to a closed bank ends at once, with no resp_last.
// - LMR: mode_bl <= A2:0, mode_cl <= A5:4 (values other than 2 or 3 are stored as 3), wbm <= A9.
//   LMR or REF while any bank_open: resp_err, command ignored.
// - Geometry (C = col bits, R = row bits), by bus_width/mem_size:
//   BW8: C = 9/10/10 for 64/128/256. BW16: C = 8/9/9. BW32: C = 8/8/8.
//   R = 12/12/13 for 64/128/256, except BW32+64 gives R = 11.
//   bas=0: resp_adr = {row[R-1:0], bank, col[C-1:0], 2'b00}.
//   bas=1: resp_adr = {bank, row[R-1:0], col[C-1:0], 2'b00}. Unused upper bits are 0.
// - RD/WR to an open bank: load col <= A(C-1:0). Beat count: BL code 0/1/2/3 gives 1/2/4/8
//   beats. Code 7 is full page (2^C beats). Other codes are treated as 1.
//   The WR burst length is forced to 1 when wbm=1.
// - Column advance is sequential and wraps inside the BL-aligned block
//   (col[k-1:0] increments, upper bits are held). Full page wraps modulo 2^C.
// - WR beats appear on resp_* in the cycle after the command, then one beat per
//   cycle. RD beats appear mode_cl cycles later than a WR beat would. They pass
//   through a CL_MAX-deep delay line tapped at mode_cl.
// - A new RD/WR during a burst truncates the old one; the new first beat follows
//   at normal timing. Read beats already in the delay line still drain.
//   BT stops column generation next cycle; in-flight read beats drain.
// - RD/WR to a closed bank: resp_err, no beats.
// - resp_last is high on the final beat only. For a 1-beat burst, resp_valid and
//   resp_last are high together. Errors do not alter bank or mode state.
// TESTING
// 1 Reset, then check outputs -> all 0, mode_cl=2, bank_open=0.
// 2 LMR A=0x022 (CL2, BL4), then ACT bank1 row 0x123, then RD col 0x06.
//   Config BW32/64, bas=0 -> 4 beats starting 3 cycles after RD.
//   Addresses 0x123418, 0x12341C, 0x123410, 0x123414; resp_last on the 4th beat.
// 3 LMR A=0x033 (CL3, BL8), then ACT bank0 row 5, then WR col 0xFE, BW8/256 bas=1.
//   Expect 8 write beats from the cycle after WR. Columns FE, FF, F8..FD, with bit 2+ = {00, row5, col}.
// 4 ACT bank2 twice -> resp_err on the 2nd ACT. RD to bank3 (closed) -> resp_err, resp_valid stays 0.
// 5 Full-page RD at col 0xFF (BW32/64), then BT after 3 beats -> cols FF, 00, 01.
//   No more beats after the drain; resp_last is never asserted.
// 6 PRE A10=1 mid-WR burst -> bank_open=0 and the burst ends. Then LMR -> accepted, with no resp_err.

Source files
------------

// File: rtl/mc_sdram_adr_decode.sv
// Memory-side SDRAM address decoder: tracks bank rows and the mode register from
// the command pins and rebuilds the byte address of every burst beat.
module mc_sdram_adr_decode #(
   parameter int CL_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] csc,
   input  logic        cs_,
   input  logic        ras_,
   input  logic        cas_,
   input  logic        we_,
   input  logic [23:0] mc_addr,
   output logic        resp_valid,
   output logic        resp_we,
   output logic [31:0] resp_adr,
   output logic        resp_last,
   output logic        resp_err,
   output logic [3:0]  bank_open,
   output logic [2:0]  mode_bl,
   output logic [1:0]  mode_cl
);

   localparam logic [2:0] CMD_NOP = 3'b111;
   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_RD  = 3'b101;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_BT  = 3'b110;
   localparam logic [2:0] CMD_PRE = 3'b010;
   localparam logic [2:0] CMD_REF = 3'b001;
   localparam logic [2:0] CMD_LMR = 3'b000;

   logic [12:0] row_q [4];
   logic [12:0] row_d [4];
   logic [3:0]  bank_open_q, bank_open_d;
   logic [2:0]  mode_bl_q, mode_bl_d;
   logic [1:0]  mode_cl_q, mode_cl_d;
   logic        wbm_q, wbm_d;
   logic        act_q, act_d;
   logic        bwe_q, bwe_d;
   logic [1:0]  bbank_q, bbank_d;
   logic [9:0]  col_q, col_d;
   logic [10:0] cnt_q, cnt_d;
   logic [9:0]  mask_q, mask_d;
   logic        err_q, err_d;

   logic [CL_MAX-1:0] dl_vld_q, dl_vld_d;
   logic [CL_MAX-1:0] dl_last_q, dl_last_d;
   logic [31:0]       dl_adr_q [CL_MAX];
   logic [31:0]       dl_adr_d [CL_MAX];

   logic [2:0]  cmd;
   logic [1:0]  cmd_bank;
   logic [5:0]  col_bits, row_bits;
   logic [9:0]  col_mask;
   logic [10:0] bl_beats;
   logic [10:0] bl_beats_m1;
   logic [9:0]  bl_mask;
   logic [31:0] gen_adr;
   logic        gen_last;
   int          tap_idx;
   logic        tap_hit;
   logic        unused_bits;

   assign unused_bits = ^{csc[31:10], csc[8], csc[3:0], mc_addr[23:15]};

   assign cmd      = cs_ ? CMD_NOP : {ras_, cas_, we_};
   assign cmd_bank = mc_addr[14:13];

   function automatic logic [31:0] beat_adr(input logic [12:0] row, input logic [1:0] bank,
                                            input logic [9:0] col, input logic [5:0] cb,
                                            input logic [5:0] rb, input logic bas);
      logic [31:0] row_m, col_m, bank_w;
      row_m  = {19'd0, row} & ((32'd1 << rb) - 32'd1);
      col_m  = {22'd0, col} & ((32'd1 << cb) - 32'd1);
      bank_w = {30'd0, bank};
      if (bas)
         beat_adr = (bank_w << (cb + rb + 6'd2)) | (row_m << (cb + 6'd2)) | (col_m << 2);
      else
         beat_adr = (row_m << (cb + 6'd4)) | (bank_w << (cb + 6'd2)) | (col_m << 2);
   endfunction

   // Geometry from bus width (csc[5:4]) and device size (csc[7:6]); reserved codes fall to the widest case.
   always_comb begin
      col_bits = 6'd8;
      row_bits = 6'd13;
      case (csc[5:4])
         2'b00:   col_bits = (csc[7:6] == 2'b00) ? 6'd9 : 6'd10;
         2'b01:   col_bits = (csc[7:6] == 2'b00) ? 6'd8 : 6'd9;
         default: col_bits = 6'd8;
      endcase
      case (csc[7:6])
         2'b00:   row_bits = (csc[5] == 1'b1) ? 6'd11 : 6'd12;
         2'b01:   row_bits = 6'd12;
         default: row_bits = 6'd13;
      endcase
      col_mask = 10'((11'd1 << col_bits) - 11'd1);
   end

   always_comb begin
      case (mode_bl_q)
         3'd0:    bl_beats = 11'd1;
         3'd1:    bl_beats = 11'd2;
         3'd2:    bl_beats = 11'd4;
         3'd3:    bl_beats = 11'd8;
         3'd7:    bl_beats = 11'd1 << col_bits;
         default: bl_beats = 11'd1;
      endcase
      bl_beats_m1 = bl_beats - 11'd1;
      bl_mask     = bl_beats_m1[9:0];
   end

   assign gen_adr  = beat_adr(row_q[bbank_q], bbank_q, col_q, col_bits, row_bits, csc[9]);
   assign gen_last = act_q && (cnt_q == 11'd1);

   always_comb begin
      row_d       = row_q;
      bank_open_d = bank_open_q;
      mode_bl_d   = mode_bl_q;
      mode_cl_d   = mode_cl_q;
      wbm_d       = wbm_q;
      act_d       = act_q;
      bwe_d       = bwe_q;
      bbank_d     = bbank_q;
      col_d       = col_q;
      cnt_d       = cnt_q;
      mask_d      = mask_q;
      err_d       = 1'b0;
      // Column advance wraps inside the aligned block selected by mask_q.
      if (act_q) begin
         col_d = (col_q & ~mask_q) | ((col_q + 10'd1) & mask_q);
         cnt_d = cnt_q - 11'd1;
         if (cnt_q == 11'd1)
            act_d = 1'b0;
      end
      case (cmd)
         CMD_ACT: begin
            if (bank_open_q[cmd_bank]) begin
               err_d = 1'b1;
            end else begin
               row_d[cmd_bank]       = mc_addr[12:0];
               bank_open_d[cmd_bank] = 1'b1;
            end
         end
         CMD_PRE: begin
            if (mc_addr[10]) begin
               bank_open_d = 4'b0000;
               act_d       = 1'b0;
            end else begin
               bank_open_d[cmd_bank] = 1'b0;
               if (bbank_q == cmd_bank)
                  act_d = 1'b0;
            end
         end
         CMD_LMR, CMD_REF: begin
            if (|bank_open_q) begin
               err_d = 1'b1;
            end else if (cmd == CMD_LMR) begin
               mode_bl_d = mc_addr[2:0];
               mode_cl_d = (mc_addr[5:4] == 2'd2) ? 2'd2 : 2'd3;
               wbm_d     = mc_addr[9];
            end
         end
         CMD_RD, CMD_WR: begin
            if (!bank_open_q[cmd_bank]) begin
               err_d = 1'b1;
            end else begin
               act_d   = 1'b1;
               bwe_d   = (cmd == CMD_WR);
               bbank_d = cmd_bank;
               col_d   = mc_addr[9:0] & col_mask;
               if ((cmd == CMD_WR) && wbm_q) begin
                  cnt_d  = 11'd1;
                  mask_d = 10'd0;
               end else begin
                  cnt_d  = bl_beats;
                  mask_d = bl_mask;
               end
            end
         end
         CMD_BT:  act_d = 1'b0;
         default: ;
      endcase
   end

   // Read beats enter the delay line the cycle a write beat would be shown.
   always_comb begin
      dl_vld_d[0]  = act_q & ~bwe_q;
      dl_last_d[0] = gen_last & ~bwe_q;
      dl_adr_d[0]  = gen_adr;
      for (int i = 1; i < CL_MAX; i++) begin
         dl_vld_d[i]  = dl_vld_q[i-1];
         dl_last_d[i] = dl_last_q[i-1];
         dl_adr_d[i]  = dl_adr_q[i-1];
      end
   end

   always_comb begin
      tap_idx = int'(mode_cl_q) - 1;
      if (tap_idx > CL_MAX - 1)
         tap_idx = CL_MAX - 1;
      if (tap_idx < 0)
         tap_idx = 0;
   end

   // A draining read beat takes the bus ahead of a write beat in the same cycle.
   always_comb begin
      resp_valid = 1'b0;
      resp_we    = 1'b0;
      resp_adr   = 32'd0;
      resp_last  = 1'b0;
      tap_hit    = 1'b0;
      for (int i = 0; i < CL_MAX; i++) begin
         if ((i == tap_idx) && dl_vld_q[i]) begin
            tap_hit    = 1'b1;
            resp_valid = 1'b1;
            resp_adr   = dl_adr_q[i];
            resp_last  = dl_last_q[i];
         end
      end
      if (!tap_hit && act_q && bwe_q) begin
         resp_valid = 1'b1;
         resp_we    = 1'b1;
         resp_adr   = gen_adr;
         resp_last  = gen_last;
      end
   end

   assign resp_err  = err_q;
   assign bank_open = bank_open_q;
   assign mode_bl   = mode_bl_q;
   assign mode_cl   = mode_cl_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 4; b++)
            row_q[b] <= 13'd0;
         bank_open_q <= 4'b0000;
         mode_bl_q   <= 3'd0;
         mode_cl_q   <= 2'd2;
         wbm_q       <= 1'b0;
         act_q       <= 1'b0;
         bwe_q       <= 1'b0;
         bbank_q     <= 2'd0;
         col_q       <= 10'd0;
         cnt_q       <= 11'd0;
         mask_q      <= 10'd0;
         err_q       <= 1'b0;
         dl_vld_q    <= '0;
         dl_last_q   <= '0;
         for (int i = 0; i < CL_MAX; i++)
            dl_adr_q[i] <= 32'd0;
      end else begin
         row_q       <= row_d;
         bank_open_q <= bank_open_d;
         mode_bl_q   <= mode_bl_d;
         mode_cl_q   <= mode_cl_d;
         wbm_q       <= wbm_d;
         act_q       <= act_d;
         bwe_q       <= bwe_d;
         bbank_q     <= bbank_d;
         col_q       <= col_d;
         cnt_q       <= cnt_d;
         mask_q      <= mask_d;
         err_q       <= err_d;
         dl_vld_q    <= dl_vld_d;
         dl_last_q   <= dl_last_d;
         dl_adr_q    <= dl_adr_d;
      end
   end

endmodule

// File: tb/tb_mc_sdram_adr_decode.sv
// Directed bench for mc_sdram_adr_decode: drives SDRAM commands and checks the
// rebuilt beat addresses, timing, error pulses and bank/mode state.
module tb_mc_sdram_adr_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] csc;
   logic        cs_, ras_, cas_, we_;
   logic [23:0] mc_addr;
   logic        resp_valid, resp_we, resp_last, resp_err;
   logic [31:0] resp_adr;
   logic [3:0]  bank_open;
   logic [2:0]  mode_bl;
   logic [1:0]  mode_cl;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int cmd_cyc = 0;
   int base_cyc = 0;

   logic [31:0] q_adr [$];
   int          q_cyc [$];
   logic        q_last [$];
   logic        q_we [$];
   logic [31:0] exp_adr [8];

   mc_sdram_adr_decode #(.CL_MAX(3)) dut (
      .clk(clk), .rst(rst), .csc(csc), .cs_(cs_), .ras_(ras_), .cas_(cas_), .we_(we_),
      .mc_addr(mc_addr), .resp_valid(resp_valid), .resp_we(resp_we), .resp_adr(resp_adr),
      .resp_last(resp_last), .resp_err(resp_err), .bank_open(bank_open),
      .mode_bl(mode_bl), .mode_cl(mode_cl)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (resp_valid) begin
         q_adr.push_back(resp_adr);
         q_cyc.push_back(cyc);
         q_last.push_back(resp_last);
         q_we.push_back(resp_we);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cmd(input logic [2:0] c, input logic [1:0] bank, input logic [12:0] a);
      cs_ = 1'b0;
      {ras_, cas_, we_} = c;
      mc_addr = {9'd0, bank, a};
      cmd_cyc = cyc;
      @(posedge clk);
      #1;
      cs_ = 1'b1;
      {ras_, cas_, we_} = 3'b111;
      mc_addr = 24'd0;
   endtask

   task automatic nop(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_beats();
      q_adr.delete();
      q_cyc.delete();
      q_last.delete();
      q_we.delete();
   endtask

   task automatic check_burst(input string tag, input int n, input int off0,
                              input logic last_final, input logic we);
      chk({tag, "_count"}, 32'(q_adr.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < q_adr.size()) begin
            chk({tag, "_adr"}, q_adr[i], exp_adr[i]);
            chk({tag, "_ofs"}, 32'(q_cyc[i] - base_cyc), 32'(off0 + i));
            chk({tag, "_last"}, {31'd0, q_last[i]}, {31'd0, last_final && (i == n - 1)});
            chk({tag, "_we"}, {31'd0, q_we[i]}, {31'd0, we});
         end
      end
   endtask

   localparam logic [2:0] ACT = 3'b011, RD = 3'b101, WR = 3'b100, BT = 3'b110,
                          PRE = 3'b010, LMR = 3'b000;

   initial begin
      rst = 1'b1;
      csc = 32'd0;
      cs_ = 1'b1;
      {ras_, cas_, we_} = 3'b111;
      mc_addr = 24'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Test 1: reset state
      chk("rst_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_we", {31'd0, resp_we}, 32'd0);
      chk("rst_adr", resp_adr, 32'd0);
      chk("rst_last", {31'd0, resp_last}, 32'd0);
      chk("rst_err", {31'd0, resp_err}, 32'd0);
      chk("rst_bank_open", {28'd0, bank_open}, 32'd0);
      chk("rst_mode_bl", {29'd0, mode_bl}, 32'd0);
      chk("rst_mode_cl", {30'd0, mode_cl}, 32'd2);

      // Test 2: CL2 BL4 read, BW32/64, bas=0
      csc = 32'h0000_0020;
      cmd(LMR, 2'd0, 13'h022);
      chk("t2_mode_cl", {30'd0, mode_cl}, 32'd2);
      chk("t2_mode_bl", {29'd0, mode_bl}, 32'd2);
      cmd(ACT, 2'd1, 13'h123);
      chk("t2_bank_open", {28'd0, bank_open}, 32'h2);
      clear_beats();
      cmd(RD, 2'd1, 13'h006);
      base_cyc = cmd_cyc;
      nop(8);
      exp_adr[0] = 32'h0012_3418;
      exp_adr[1] = 32'h0012_341C;
      exp_adr[2] = 32'h0012_3410;
      exp_adr[3] = 32'h0012_3414;
      check_burst("t2", 4, 3, 1'b1, 1'b0);

      // Test 3: CL3 BL8 write, BW8/256, bas=1
      cmd(PRE, 2'd0, 13'h400);
      chk("t3_pre_all", {28'd0, bank_open}, 32'd0);
      csc = 32'h0000_0280;
      cmd(LMR, 2'd0, 13'h033);
      chk("t3_mode_cl", {30'd0, mode_cl}, 32'd3);
      cmd(ACT, 2'd0, 13'h005);
      clear_beats();
      cmd(WR, 2'd0, 13'h0FE);
      base_cyc = cmd_cyc;
      nop(10);
      exp_adr[0] = 32'h0000_53F8;
      exp_adr[1] = 32'h0000_53FC;
      exp_adr[2] = 32'h0000_53E0;
      exp_adr[3] = 32'h0000_53E4;
      exp_adr[4] = 32'h0000_53E8;
      exp_adr[5] = 32'h0000_53EC;
      exp_adr[6] = 32'h0000_53F0;
      exp_adr[7] = 32'h0000_53F4;
      check_burst("t3", 8, 1, 1'b1, 1'b1);

      // Test 4: error cases
      cmd(ACT, 2'd2, 13'h010);
      chk("t4_act_ok_err", {31'd0, resp_err}, 32'd0);
      chk("t4_bank_open", {28'd0, bank_open}, 32'h5);
      cmd(ACT, 2'd2, 13'h020);
      chk("t4_act_twice_err", {31'd0, resp_err}, 32'd1);
      nop(1);
      chk("t4_err_pulse", {31'd0, resp_err}, 32'd0);
      cmd(LMR, 2'd0, 13'h022);
      chk("t4_lmr_open_err", {31'd0, resp_err}, 32'd1);
      chk("t4_lmr_cl_kept", {30'd0, mode_cl}, 32'd3);
      chk("t4_lmr_bl_kept", {29'd0, mode_bl}, 32'd3);
      clear_beats();
      cmd(RD, 2'd3, 13'h000);
      chk("t4_rd_closed_err", {31'd0, resp_err}, 32'd1);
      nop(6);
      chk("t4_rd_closed_beats", 32'(q_adr.size()), 32'd0);

      // Test 5: full-page read stopped by BT
      cmd(PRE, 2'd0, 13'h400);
      cmd(LMR, 2'd0, 13'h027);
      chk("t5_mode_bl", {29'd0, mode_bl}, 32'd7);
      csc = 32'h0000_0020;
      cmd(ACT, 2'd1, 13'h123);
      clear_beats();
      cmd(RD, 2'd1, 13'h0FF);
      base_cyc = cmd_cyc;
      nop(2);
      cmd(BT, 2'd0, 13'h000);
      nop(6);
      exp_adr[0] = 32'h0012_37FC;
      exp_adr[1] = 32'h0012_3400;
      exp_adr[2] = 32'h0012_3404;
      check_burst("t5", 3, 3, 1'b0, 1'b0);

      // Test 6: precharge-all aborts a write burst, then LMR is accepted
      clear_beats();
      cmd(WR, 2'd1, 13'h000);
      base_cyc = cmd_cyc;
      nop(2);
      cmd(PRE, 2'd0, 13'h400);
      chk("t6_bank_open", {28'd0, bank_open}, 32'd0);
      nop(4);
      exp_adr[0] = 32'h0012_3400;
      exp_adr[1] = 32'h0012_3404;
      exp_adr[2] = 32'h0012_3408;
      check_burst("t6", 3, 1, 1'b0, 1'b1);
      cmd(LMR, 2'd0, 13'h032);
      chk("t6_lmr_err", {31'd0, resp_err}, 32'd0);
      chk("t6_mode_cl", {30'd0, mode_cl}, 32'd3);
      chk("t6_mode_bl", {29'd0, mode_bl}, 32'd2);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
